pixel_stream_tx: RTL and testbench
==================================

PIXEL_STREAM_TX -- requirements
Module: pixel_stream_tx

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 640, meaning pixels per line.
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 480, meaning lines per frame.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), meaning pixel buffer entries.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 The block SHALL have port enable, input, 1, meaning accept new pixels when high.
REQ-007 The block SHALL have port pix_in, input, 24, meaning shaded pixel {R[7:0],G[7:0],B[7:0]}.
REQ-008 The block SHALL have port pix_valid, input, 1, meaning pix_in holds a valid pixel.
REQ-009 The block SHALL have port pix_ready, output, 1, meaning the block can accept pix_in.
REQ-010 The block SHALL have port out_tdata, output, 32, meaning {8'h00, R, G, B}.
REQ-011 The block SHALL have port out_tvalid, output, 1, meaning out_tdata and sideband are valid.
REQ-012 The block SHALL have port out_tready, input, 1, meaning the sink accepts the current beat.
REQ-013 The block SHALL have port out_tuser, output, 1, meaning start of frame (first pixel of frame).
REQ-014 The block SHALL have port out_tlast, output, 1, meaning last pixel of a line.
REQ-015 The block SHALL have port frame_done, output, 1, meaning one-cycle pulse after the final pixel of a frame transfers.

Function
REQ-016 Input transfer SHALL occur when pix_valid && pix_ready on a rising clk edge.
REQ-017 pix_ready SHALL equal enable && !fifo_full, registered-state only; it SHALL NOT depend combinationally on out_tready.
REQ-018 Accepted pixels SHALL be written into a FIFO of FIFO_DEPTH entries, read in arrival order; no pixel is dropped or duplicated.
REQ-019 out_tvalid SHALL equal !fifo_empty; out_tdata SHALL present the FIFO head, zero-extended in bits 31:24.
REQ-020 Latency: a pixel accepted into an empty FIFO at edge N SHALL appear on out_tdata with out_tvalid high after edge N (one cycle).
REQ-021 Output transfer SHALL occur when out_tvalid && out_tready; FIFO pops on that edge.
REQ-022 While out_tvalid && !out_tready, out_tdata, out_tuser, out_tlast SHALL remain stable.
REQ-023 Simultaneous push and pop SHALL be legal at any occupancy where push is permitted; occupancy is then unchanged.
REQ-024 Occupancy counter SHALL range 0..FIFO_DEPTH; read/write pointers wrap modulo FIFO_DEPTH.
REQ-025 Column counter x (0..IMG_WIDTH-1) and row counter y (0..IMG_HEIGHT-1) SHALL advance only on output transfers.
REQ-026 On transfer with x==IMG_WIDTH-1, x SHALL wrap to 0 and y increment; if also y==IMG_HEIGHT-1, y SHALL wrap to 0.
REQ-027 out_tuser SHALL be high exactly when x==0 && y==0 and out_tvalid high.
REQ-028 out_tlast SHALL be high exactly when x==IMG_WIDTH-1 and out_tvalid high.
REQ-029 frame_done SHALL pulse high for exactly one cycle on the cycle following the transfer with x==IMG_WIDTH-1 && y==IMG_HEIGHT-1.
REQ-030 enable low SHALL block input only; buffered pixels continue to drain and counters continue.
REQ-031 Counter widths SHALL be $clog2 of the respective dimension; no overflow beyond wrap points.

Reset
REQ-032 On rst_n low, asynchronously: FIFO emptied, pointers/occupancy 0, x=0, y=0, frame_done=0, out_tvalid=0, pix_ready=0.
REQ-033 Reset asserted mid-frame SHALL discard buffered pixels; first transfer after reset carries out_tuser=1.
REQ-034 After rst_n deasserts, pix_ready SHALL rise on the first edge where enable is high and FIFO not full.

Verification (IMG_WIDTH=4, IMG_HEIGHT=2, FIFO_DEPTH=4)
REQ-035 Stream 8 pixels 0x000001..0x000008, out_tready=1 -> tdata 0x00000001..0x00000008, tuser on beat 1, tlast on beats 4 and 8, frame_done one cycle after beat 8.
REQ-036 out_tready=0, push 5 pixels -> 4 accepted, pix_ready low after 4th, tdata holds 0x00000001 stable; release tready -> all 4 drain in order, then 5th accepted.
REQ-037 FIFO at 3 entries, push and pop same cycle for 6 cycles -> occupancy stays 3, order preserved.
REQ-038 enable=0 with 2 pixels buffered -> pix_ready=0, both pixels still output, x advances to 2.
REQ-039 Assert rst_n low after beat 5 of a frame, release, stream 0xABCDEF -> tdata 0x00ABCDEF with tuser=1, no residual pixels.
REQ-040 Random tvalid/tready backpressure over 3 frames -> scoreboard exact match, tuser every 8 beats, tlast every 4 beats, 3 frame_done pulses.

Source files
------------

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx
//
// Purpose:
//   Buffers shaded 24-bit pixels in a small FIFO and presents them as an
//   AXI4-Stream-style video output. Start-of-frame (tuser) and end-of-line
//   (tlast) sideband come from column/row counters. These counters advance
//   only when a beat is actually accepted by the sink.
//
// Parameters:
//   IMG_WIDTH  - pixels per line
//   IMG_HEIGHT - lines per frame
//   FIFO_DEPTH - pixel buffer entries (power of two, >= 2)
//
// Ports:
//   clk        - single clock, all logic on the rising edge
//   rst_n      - asynchronous active-low reset
//   enable     - allow new pixels to be accepted
//   pix_in     - shaded pixel {R,G,B}
//   pix_valid  - pix_in holds a valid pixel
//   pix_ready  - block can accept pix_in this cycle
//   out_tdata  - {8'h00, R, G, B} of the FIFO head
//   out_tvalid - out_tdata and sideband are valid
//   out_tready - sink accepts the current beat
//   out_tuser  - first pixel of a frame
//   out_tlast  - last pixel of a line
//   frame_done - one-cycle pulse after the final pixel of a frame transfers

module pixel_stream_tx #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [23:0] pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [31:0] out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        out_tuser,
  output logic        out_tlast,
  output logic        frame_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);

  logic [23:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          running;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          frame_done_q;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic last_of_frame;

  // Handshake decode. pix_ready is built only from registered state and
  // enable, so there is no combinational path from out_tready back to the
  // pixel source. The running flag holds pix_ready low while in reset and
  // until the first clock edge after reset is released.
  always_comb begin
    fifo_full     = (count == DEPTH_C);
    fifo_empty    = (count == '0);
    pix_ready     = running && enable && !fifo_full;
    out_tvalid    = !fifo_empty;
    push          = pix_valid && pix_ready;
    pop           = out_tvalid && out_tready;
    last_of_frame = (x == X_LAST) && (y == Y_LAST);
  end

  // Output beat: FIFO head, zero-extended in the top byte, plus sideband
  // derived from the position of the beat currently at the head.
  always_comb begin
    out_tdata  = {8'h00, mem[rd_ptr]};
    out_tuser  = out_tvalid && (x == '0) && (y == '0);
    out_tlast  = out_tvalid && (x == X_LAST);
    frame_done = frame_done_q;
  end

  // Storage array. It is not reset; the pointers and occupancy alone
  // decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pix_in;
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because the
  // depth is a power of two. A simultaneous push and pop leaves the
  // occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      running <= 1'b0;
    end else begin
      running <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Raster position of the head pixel. It advances only on output
  // transfers, so backpressure and a disabled input never skew the
  // sideband. Column wraps into the next row, and row wraps at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (pop) begin
      if (x == X_LAST) begin
        x <= '0;
        if (y == Y_LAST) begin
          y <= '0;
        end else begin
          y <= y + 1'b1;
        end
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Frame-complete pulse. It is registered, so it appears on the cycle
  // after the final pixel of the frame has been accepted by the sink.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= pop && last_of_frame;
    end
  end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb_pixel_stream_tx
//
// Purpose:
//   Directed bench for pixel_stream_tx in a tiny 4x2 frame with a 4-entry
//   FIFO. It covers reset, streaming, backpressure, concurrent push/pop,
//   enable gating, mid-frame reset, and a randomised handshake run that is
//   checked against a small queue model.
//
// Ports: none (top-level bench).

module tb_pixel_stream_tx;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [23:0] pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready;
  logic        out_tuser;
  logic        out_tlast;
  logic        frame_done;

  int compared   = 0;
  int mismatched = 0;

  pixel_stream_tx #(
    .IMG_WIDTH (4),
    .IMG_HEIGHT(2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .out_tdata (out_tdata),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready),
    .out_tuser (out_tuser),
    .out_tlast (out_tlast),
    .frame_done(frame_done)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the pixel source and sink handshake inputs together
  task automatic applyStimulus(input logic v, input logic [23:0] d, input logic rdy);
    pix_valid  = v;
    pix_in     = d;
    out_tready = rdy;
  endtask

  // Advance one rising edge and settle just after it
  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point, counted and asserted
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Safety net in case the main sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [23:0] q[$];
    logic [23:0] pixel;
    int pushed;
    int popped;
    int exp_fd;
    int dut_fd;
    int mx;
    int my;
    logic v;
    logic r;
    logic do_push;
    logic do_pop;
    logic fd_exp;

    // ---------------- reset ----------------
    rst_n = 1'b0;
    enable = 1'b0;
    applyStimulus(1'b0, 24'h0, 1'b0);
    #12;
    checkOutput("rst_tvalid", 32'(out_tvalid), 32'd0);
    checkOutput("rst_pix_ready", 32'(pix_ready), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    enable = 1'b1;
    #1;
    checkOutput("rst_ready_en", 32'(pix_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_before_edge", 32'(pix_ready), 32'd0);
    waitCycle();
    checkOutput("ready_after_edge", 32'(pix_ready), 32'd1);

    // ---------------- full frame streamed ----------------
    $display("[TB] streaming one frame");
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 24'(i), 1'b1);
      waitCycle();
      checkOutput($sformatf("s_tdata%0d", i), out_tdata, 32'(i));
      checkOutput($sformatf("s_tvalid%0d", i), 32'(out_tvalid), 32'd1);
      checkOutput($sformatf("s_tuser%0d", i), 32'(out_tuser), 32'(i == 1));
      checkOutput($sformatf("s_tlast%0d", i), 32'(out_tlast), 32'((i == 4) || (i == 8)));
      checkOutput($sformatf("s_fdone%0d", i), 32'(frame_done), 32'd0);
    end
    applyStimulus(1'b0, 24'h0, 1'b1);
    waitCycle();
    checkOutput("s_fdone_pulse", 32'(frame_done), 32'd1);
    checkOutput("s_empty", 32'(out_tvalid), 32'd0);
    waitCycle();
    checkOutput("s_fdone_clear", 32'(frame_done), 32'd0);

    // ---------------- backpressure fills FIFO ----------------
    $display("[TB] backpressure");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 24'h11 + 24'(k), 1'b0);
      waitCycle();
      checkOutput($sformatf("bp_ready%0d", k), 32'(pix_ready), 32'(k < 3));
    end
    applyStimulus(1'b1, 24'h15, 1'b0);
    for (int k = 0; k < 2; k++) begin
      waitCycle();
      checkOutput($sformatf("bp_hold_data%0d", k), out_tdata, 32'h00000011);
      checkOutput($sformatf("bp_hold_tuser%0d", k), 32'(out_tuser), 32'd1);
      checkOutput($sformatf("bp_hold_ready%0d", k), 32'(pix_ready), 32'd0);
    end
    applyStimulus(1'b1, 24'h15, 1'b1);
    waitCycle();
    checkOutput("bp_d12", out_tdata, 32'h00000012);
    checkOutput("bp_ready_reopen", 32'(pix_ready), 32'd1);
    waitCycle();
    checkOutput("bp_d13", out_tdata, 32'h00000013);
    applyStimulus(1'b0, 24'h0, 1'b1);
    waitCycle();
    checkOutput("bp_d14", out_tdata, 32'h00000014);
    checkOutput("bp_tlast14", 32'(out_tlast), 32'd1);
    waitCycle();
    checkOutput("bp_d15", out_tdata, 32'h00000015);
    checkOutput("bp_tuser15", 32'(out_tuser), 32'd0);
    waitCycle();
    checkOutput("bp_drained", 32'(out_tvalid), 32'd0);

    // ---------------- concurrent push/pop at occupancy 3 ----------------
    $display("[TB] concurrent push and pop");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 24'h21 + 24'(k), 1'b0);
      waitCycle();
    end
    checkOutput("pp_head21", out_tdata, 32'h00000021);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 24'h24 + 24'(k), 1'b1);
      waitCycle();
      checkOutput($sformatf("pp_data%0d", k), out_tdata, 32'h22 + 32'(k));
      checkOutput($sformatf("pp_ready%0d", k), 32'(pix_ready), 32'd1);
      checkOutput($sformatf("pp_tuser%0d", k), 32'(out_tuser), 32'(k == 2));
      checkOutput($sformatf("pp_tlast%0d", k), 32'(out_tlast), 32'((k == 1) || (k == 5)));
    end
    applyStimulus(1'b0, 24'h0, 1'b1);
    waitCycle();
    checkOutput("pp_d28", out_tdata, 32'h00000028);
    waitCycle();
    checkOutput("pp_d29", out_tdata, 32'h00000029);
    waitCycle();
    checkOutput("pp_empty", 32'(out_tvalid), 32'd0);

    // ---------------- enable low drains buffered pixels ----------------
    $display("[TB] enable gating");
    applyStimulus(1'b1, 24'h31, 1'b0);
    waitCycle();
    applyStimulus(1'b1, 24'h32, 1'b0);
    waitCycle();
    enable = 1'b0;
    applyStimulus(1'b1, 24'h33, 1'b0);
    #1;
    checkOutput("en_ready_low", 32'(pix_ready), 32'd0);
    checkOutput("en_d31", out_tdata, 32'h00000031);
    checkOutput("en_tlast31", 32'(out_tlast), 32'd0);
    applyStimulus(1'b1, 24'h33, 1'b1);
    waitCycle();
    checkOutput("en_d32", out_tdata, 32'h00000032);
    checkOutput("en_tlast32", 32'(out_tlast), 32'd1);
    checkOutput("en_ready_still_low", 32'(pix_ready), 32'd0);
    waitCycle();
    checkOutput("en_empty", 32'(out_tvalid), 32'd0);
    checkOutput("en_fdone", 32'(frame_done), 32'd1);
    waitCycle();
    checkOutput("en_not_accepted", 32'(out_tvalid), 32'd0);
    checkOutput("en_fdone_clear", 32'(frame_done), 32'd0);
    enable = 1'b1;
    applyStimulus(1'b0, 24'h0, 1'b0);
    #1;
    checkOutput("en_ready_back", 32'(pix_ready), 32'd1);

    // ---------------- mid-frame reset ----------------
    $display("[TB] mid-frame reset");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 24'h41 + 24'(k), 1'b1);
      waitCycle();
      checkOutput($sformatf("mr_data%0d", k), out_tdata, 32'h41 + 32'(k));
    end
    applyStimulus(1'b1, 24'h47, 1'b0);
    waitCycle();
    checkOutput("mr_head46", out_tdata, 32'h00000046);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_tvalid", 32'(out_tvalid), 32'd0);
    checkOutput("mr_ready", 32'(pix_ready), 32'd0);
    applyStimulus(1'b0, 24'h0, 1'b0);
    #3;
    rst_n = 1'b1;
    waitCycle();
    checkOutput("mr_ready_after", 32'(pix_ready), 32'd1);
    checkOutput("mr_no_residual", 32'(out_tvalid), 32'd0);
    applyStimulus(1'b1, 24'hABCDEF, 1'b0);
    waitCycle();
    checkOutput("mr_data", out_tdata, 32'h00ABCDEF);
    checkOutput("mr_tuser", 32'(out_tuser), 32'd1);
    checkOutput("mr_tvalid_new", 32'(out_tvalid), 32'd1);
    applyStimulus(1'b0, 24'h0, 1'b1);
    waitCycle();
    checkOutput("mr_drained", 32'(out_tvalid), 32'd0);

    // ---------------- random handshakes over 3 frames ----------------
    $display("[TB] random handshakes");
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b0, 24'h0, 1'b0);
    waitCycle();
    pushed = 0;
    popped = 0;
    exp_fd = 0;
    dut_fd = 0;
    mx = 0;
    my = 0;
    for (int it = 0; it < 3000 && popped < 24; it++) begin
      v = (pushed < 24) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      pixel = 24'h500000 + 24'(pushed);
      applyStimulus(v, pixel, r);
      do_push = v && (q.size() < 4);
      do_pop = r && (q.size() > 0);
      waitCycle();
      fd_exp = do_pop && (mx == 3) && (my == 1);
      if (do_pop) begin
        void'(q.pop_front());
        popped++;
        if (mx == 3) begin
          mx = 0;
          my = (my == 1) ? 0 : 1;
        end else begin
          mx++;
        end
      end
      if (do_push) begin
        q.push_back(pixel);
        pushed++;
      end
      if (fd_exp) exp_fd++;
      if (frame_done) dut_fd++;
      checkOutput("rnd_fdone", 32'(frame_done), 32'(fd_exp));
      checkOutput("rnd_tvalid", 32'(out_tvalid), 32'(q.size() > 0));
      checkOutput("rnd_ready", 32'(pix_ready), 32'(q.size() < 4));
      if (q.size() > 0) begin
        checkOutput("rnd_tdata", out_tdata, {8'h00, q[0]});
        checkOutput("rnd_tuser", 32'(out_tuser), 32'((mx == 0) && (my == 0)));
        checkOutput("rnd_tlast", 32'(out_tlast), 32'(mx == 3));
      end
    end
    checkOutput("rnd_beats", 32'(popped), 32'd24);
    checkOutput("rnd_fdone_model", 32'(exp_fd), 32'd3);
    checkOutput("rnd_fdone_count", 32'(dut_fd), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
